// File: rtl/branch_resolve_unit.sv
// Branch resolution for the EX stage: EX register, compare, redirect generation,
// a 16-entry 2-bit predictor and branch/mispredict event counters.
module branch_resolve_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [2:0]  id_cmp_ctrl,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_target,
  input  logic        id_pred_taken,
  input  logic [31:0] if_pc,
  output logic        if_pred_taken,
  output logic        ex_redirect,
  output logic [31:0] ex_redirect_pc,
  output logic        ex_taken,
  output logic [31:0] perf_branches,
  output logic [31:0] perf_mispredicts
);

  localparam logic [2:0] CMP_NONE = 3'd0;
  localparam logic [2:0] CMP_EQ   = 3'd1;
  localparam logic [2:0] CMP_NE   = 3'd2;
  localparam logic [2:0] CMP_LT   = 3'd3;
  localparam logic [2:0] CMP_GE   = 3'd4;
  localparam logic [2:0] CMP_LTU  = 3'd5;
  localparam logic [2:0] CMP_GEU  = 3'd6;

  logic        ex_valid;
  logic [2:0]  ex_cmp_ctrl;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [31:0] ex_target;
  logic        ex_pred_taken;

  logic [1:0]  pred_tbl [16];
  logic        cmp_res;
  logic        ex_branch;
  logic        br_update;
  logic [3:0]  upd_idx;
  logic        unused_pc_bits;

  assign unused_pc_bits = ^{if_pc[31:6], if_pc[1:0], ex_pc[1:0]};

  always_comb begin
    cmp_res = 1'b0;
    case (ex_cmp_ctrl)
      CMP_EQ:  cmp_res = (ex_rs1 == ex_rs2);
      CMP_NE:  cmp_res = (ex_rs1 != ex_rs2);
      CMP_LT:  cmp_res = ($signed(ex_rs1) <  $signed(ex_rs2));
      CMP_GE:  cmp_res = ($signed(ex_rs1) >= $signed(ex_rs2));
      CMP_LTU: cmp_res = (ex_rs1 <  ex_rs2);
      CMP_GEU: cmp_res = (ex_rs1 >= ex_rs2);
      default: cmp_res = 1'b0;
    endcase
  end

  assign ex_branch      = ex_valid && (ex_cmp_ctrl != CMP_NONE);
  assign ex_taken       = ex_branch && cmp_res;
  assign ex_redirect    = ex_branch && !stall && (ex_taken != ex_pred_taken);
  assign ex_redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
  assign br_update      = ex_branch && !stall;
  assign upd_idx        = ex_pc[5:2];

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign if_pred_taken  = pred_tbl[if_pc[5:2]][1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid         <= 1'b0;
      ex_cmp_ctrl      <= CMP_NONE;
      ex_pc            <= '0;
      ex_rs1           <= '0;
      ex_rs2           <= '0;
      ex_target        <= '0;
      ex_pred_taken    <= 1'b0;
      perf_branches    <= '0;
      perf_mispredicts <= '0;
      for (int i = 0; i < 16; i++) pred_tbl[i] <= 2'b01;
    end else begin
      // Flush only kills validity; the remaining fields keep their contents.
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (!stall) begin
        ex_valid      <= id_valid;
        ex_cmp_ctrl   <= id_cmp_ctrl;
        ex_pc         <= id_pc;
        ex_rs1        <= id_rs1_data;
        ex_rs2        <= id_rs2_data;
        ex_target     <= id_target;
        ex_pred_taken <= id_pred_taken;
      end

      if (br_update) begin
        perf_branches <= perf_branches + 32'd1;
        if (ex_taken) begin
          if (pred_tbl[upd_idx] != 2'b11) pred_tbl[upd_idx] <= pred_tbl[upd_idx] + 2'b01;
        end else begin
          if (pred_tbl[upd_idx] != 2'b00) pred_tbl[upd_idx] <= pred_tbl[upd_idx] - 2'b01;
        end
      end

      if (ex_redirect) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end

endmodule
